// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with shared counter and double-buffered settings
//
// Purpose:
//   A single period counter is shared by CHANNELS = 2**CH_BITS outputs. Each
//   channel compares the counter against its own active duty value. The counter
//   runs edge-aligned (0..P) or center-aligned (0..P..1). Period, mode and duty
//   are double-buffered and only move into the active registers at the terminal
//   cycle (TC), or on every cycle while disabled.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   en_i          run enable; when low the counter parks at 0 and outputs idle at pol_i
//   mode_i        0 = edge-aligned, 1 = center-aligned (shadowed)
//   period_i      period setting P (shadowed)
//   wr_en_i       duty write strobe
//   wr_ch_i       channel index for the duty write
//   wr_duty_i     duty value for the duty write
//   pol_i         per-channel output polarity, 1 = inverted (not shadowed)
//   out_o         registered PWM outputs
//   period_end_o  registered one-cycle pulse for the last cycle of each period

module pwm_multi #(
    parameter  int WIDTH    = 8,
    parameter  int CH_BITS  = 2,
    localparam int CHANNELS = 2**CH_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                mode_i,
    input  logic [WIDTH-1:0]    period_i,
    input  logic                wr_en_i,
    input  logic [CH_BITS-1:0]  wr_ch_i,
    input  logic [WIDTH-1:0]    wr_duty_i,
    input  logic [CHANNELS-1:0] pol_i,
    output logic [CHANNELS-1:0] out_o,
    output logic                period_end_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;      // 0 = counting up, 1 = counting down
    logic [WIDTH-1:0]    per_q;
    logic                mode_q;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    duty_q   [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic                pe_q, pe_d;

    logic [WIDTH-1:0]    cnt_step;
    logic                dir_step;
    logic                tc;
    logic                load;
    logic [CHANNELS-1:0] raw;

    // Free-running next count, ignoring enable. TC is defined as "next count
    // is zero", which covers P = 0 in both modes without a special case.
    always_comb begin
        cnt_step = '0;
        dir_step = 1'b0;
        if (!mode_q) begin
            cnt_step = (cnt_q == per_q) ? '0 : cnt_q + ONE;
        end else if (per_q == '0) begin
            cnt_step = '0;
        end else if (!dir_q) begin
            if (cnt_q == per_q) begin
                cnt_step = cnt_q - ONE;
                dir_step = 1'b1;
            end else begin
                cnt_step = cnt_q + ONE;
            end
        end else begin
            cnt_step = cnt_q - ONE;
            dir_step = 1'b1;
        end
    end

    assign tc   = (cnt_step == '0);
    // Disabled behaves like a permanent terminal cycle so the first enabled
    // cycle starts at cnt 0 with freshly loaded settings.
    assign load = !en_i || tc;

    always_comb begin
        cnt_d = en_i ? cnt_step : '0;
        dir_d = load ? 1'b0 : dir_step;
        raw   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (cnt_q < duty_q[i]);
        end
        out_d = en_i ? (raw ^ pol_i) : pol_i;
        pe_d  = en_i && tc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            per_q  <= '0;
            mode_q <= 1'b0;
            out_q  <= '0;
            pe_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            out_q <= out_d;
            pe_q  <= pe_d;
            if (wr_en_i) begin
                shadow_q[wr_ch_i] <= wr_duty_i;
            end
            if (load) begin
                per_q  <= period_i;
                mode_q <= mode_i;
                // A write landing in the load cycle bypasses the shadow so it
                // is not lost for one period.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (wr_en_i && (wr_ch_i == CH_BITS'(i))) begin
                        duty_q[i] <= wr_duty_i;
                    end else begin
                        duty_q[i] <= shadow_q[i];
                    end
                end
            end
        end
    end

    assign out_o        = out_q;
    assign period_end_o = pe_q;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator with a shared period counter, per-channel duty registers, edge- or center-aligned counting and glitch-free double-buffered updates. Period, mode and duty changes take effect only at a period boundary. It sits between a register/host write port and the pins driving LEDs, motors or other PWM loads.

## Interface
- WIDTH, 8, bit width of the counter, PERIOD and duty values
- CH_BITS, 2, channel-select width; channel count CHANNELS = 2**CH_BITS
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  reset, asynchronous, active-high
- EN  input  1  run enable
- MODE  input  1  0 = edge-aligned (up count), 1 = center-aligned (up/down)
- PERIOD  input  WIDTH  period setting P (shadowed)
- WR_EN  input  1  duty write strobe
- WR_CH  input  CH_BITS  channel index for the write
- WR_DUTY  input  WIDTH  duty value D for the write
- POL  input  CHANNELS  per-channel output polarity (1 = inverted), not shadowed
- OUT  output  CHANNELS  registered PWM outputs
- PERIOD_END  output  1  one-cycle pulse marking the last cycle of each period

## Operation
- Registers: shared counter cnt (WIDTH), direction flag (up/down), active P, active MODE, per-channel shadow duty and active duty.
- Edge mode: cnt = 0,1,…,P,0,… ; period = P+1 cycles.
- Center mode: cnt = 0,1,…,P,P−1,…,1,0,… ; period = 2P cycles; P = 0 holds cnt at 0 (1-cycle period).
- TC (terminal cycle) = cycle in which the next cnt is 0; P = 0 makes every cycle TC in either mode.
- Raw channel level = (cnt < active duty). Edge: high D cycles per period; D = 0 always low; D ≥ P+1 always high. Center: high 2D−1 cycles centred on cnt = 0 for 1 ≤ D ≤ P; D > P always high; D = 0 always low.
- OUT[i] = raw level XOR POL[i].
- WR_EN writes WR_DUTY into shadow duty[WR_CH] on any cycle.
- At the TC clock edge: active P ← PERIOD, active MODE ← MODE, all active duties ← shadow duties, direction ← up. A write in the TC cycle passes through: active duty[WR_CH] ← WR_DUTY.
- EN = 0: cnt ← 0, direction ← up, active ← shadow/inputs every cycle, OUT ← POL (inactive level), PERIOD_END ← 0. The first enabled cycle has cnt = 0 with freshly loaded values.
- The compare is full WIDTH unsigned and never overflows; cnt never exceeds active P.

## Timing
- Reset values: cnt 0, direction up, active P 0, MODE 0, all shadow and active duties 0, OUT all 0, PERIOD_END 0. Reset takes effect immediately, mid-period included; the first clocked cycle after release drives OUT = POL when EN = 0.
- Latency: OUT and PERIOD_END are registered; in cycle n+1 they reflect the cnt/TC state of cycle n. PERIOD_END is high in the cycle OUT shows the TC count.
- POL changes appear on OUT one cycle later, with no boundary wait.
- Duty/PERIOD/MODE written in a non-TC cycle affect the next period only. Writes in the TC cycle affect the immediately following period.
- Multiple writes to one channel within a period: the last one wins.

## Test plan
- Edge, P = 9, duties {3,0,10,255}, POL = 0 -> 10-cycle period; OUT[0] high 3 cycles from cnt 0; OUT[1] constantly 0; OUT[2] and OUT[3] constantly 1; PERIOD_END every 10th cycle.
- Center, P = 4, D = 2 on ch0 -> 8-cycle period; cnt sequence 0,1,2,3,4,3,2,1; OUT[0] high for 3 consecutive cycles (cnt 1↓,0,1↑); PERIOD_END at cnt 1↓.
- Shadow update: edge, P = 9, ch0 D = 3; write D = 7 at cnt 4 -> current period still 3 high, next period 7 high. Write D = 5 in the TC cycle -> the very next period is 5 high.
- PERIOD 9→4 written at cnt 2, and MODE 0→1 in the same period -> current period completes at 10 cycles, then 8-cycle center periods begin.
- EN dropped at cnt 6 with POL = 0101 -> next cycle OUT = 0101, cnt 0. Re-enable -> period restarts from cnt 0 with current shadow values; toggle POL[0] mid-period -> OUT[0] inverts one cycle later.
- Assert RST mid-period with outputs high -> OUT = 0 and PERIOD_END = 0 immediately (asynchronous); after release, all duties read as 0 (outputs at POL level).
